// File: rtl/con_ff_bank.sv
// Bank of branch-condition flags: evaluates a sign/zero predicate on bus_data and
// writes, ANDs, ORs or XORs it into one selected flag, with an optional input stage.
module con_ff_bank #(
  parameter int DATA_W    = 32,
  parameter int NUM_FLAGS = 4,
  parameter int IDX_W     = 2,
  parameter int PIPE      = 0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DATA_W-1:0]    bus_data,
  input  logic [2:0]           cond_sel,
  input  logic [1:0]           combine,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic                 CON_in,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 CONFF,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 con_valid
);

  function automatic logic evalCond(input logic signed [DATA_W-1:0] d,
                                    input logic [2:0] sel);
    logic isZero;
    logic isNeg;
    isZero = (d == '0);
    isNeg  = d[DATA_W-1];
    case (sel)
      3'd0:    return isZero;
      3'd1:    return !isZero;
      3'd2:    return !isNeg;
      3'd3:    return isNeg;
      3'd4:    return !isNeg && !isZero;
      3'd5:    return isNeg || isZero;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic combineFlag(input logic oldVal, input logic c,
                                       input logic [1:0] mode);
    case (mode)
      2'd0:    return c;
      2'd1:    return oldVal & c;
      2'd2:    return oldVal | c;
      default: return oldVal ^ c;
    endcase
  endfunction

  logic signed [DATA_W-1:0] data_p1;
  logic [2:0]               sel_p1;
  logic [1:0]               comb_p1;
  logic [IDX_W-1:0]         idx_p1;
  logic                     vld_p1;

  // Stage p0 -> p1: optional input register; only its valid bit is reset
  generate
    if (PIPE != 0) begin : gStage
      always_ff @(posedge clk) begin
        if (clr) vld_p1 <= 1'b0;
        else     vld_p1 <= CON_in;
      end
      always_ff @(posedge clk) begin
        data_p1 <= bus_data;
        sel_p1  <= cond_sel;
        comb_p1 <= combine;
        idx_p1  <= wr_idx;
      end
    end else begin : gNoStage
      assign data_p1 = bus_data;
      assign sel_p1  = cond_sel;
      assign comb_p1 = combine;
      assign idx_p1  = wr_idx;
      assign vld_p1  = CON_in;
    end
  endgenerate

  logic                 idxOk;
  logic                 wrEn;
  logic                 condBit;
  logic [NUM_FLAGS-1:0] flagsD;

  assign idxOk   = ({1'b0, idx_p1} < (IDX_W+1)'(NUM_FLAGS));
  assign wrEn    = vld_p1 && idxOk;
  assign condBit = evalCond(data_p1, sel_p1);

  always_comb begin
    flagsD = flags;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (wrEn && (idx_p1 == IDX_W'(i)))
        flagsD[i] = combineFlag(flags[i], condBit, comb_p1);
    end
  end

  // Stage p1 -> flag registers: evaluate, combine with the pre-edge value, write
  always_ff @(posedge clk) begin
    if (clr) begin
      flags     <= '0;
      con_valid <= 1'b0;
    end else begin
      flags     <= flagsD;
      con_valid <= wrEn;
    end
  end

  always_comb begin
    CONFF = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (rd_idx == IDX_W'(i)) CONFF = flags[i];
    end
  end

endmodule

// File: tb/tb_con_ff_bank.sv
// Scoreboard bench for con_ff_bank: three instances (PIPE=0, PIPE=1, three flags)
// share one stimulus stream and are each checked against a per-instance model.
module tb_con_ff_bank;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] bus_data = '0;
  logic [2:0]  cond_sel = '0;
  logic [1:0]  combine = '0;
  logic [1:0]  wr_idx = '0;
  logic        CON_in = 1'b0;
  logic [1:0]  rd_idx = '0;

  logic [3:0] fl0, fl1;
  logic [2:0] fl2;
  logic       cf0, cf1, cf2;
  logic       cv0, cv1, cv2;

  always #5 clk = ~clk;

  con_ff_bank #(.DATA_W(32), .NUM_FLAGS(4), .IDX_W(2), .PIPE(0)) dut0 (
    .clk(clk), .clr(clr), .bus_data(bus_data), .cond_sel(cond_sel), .combine(combine),
    .wr_idx(wr_idx), .CON_in(CON_in), .rd_idx(rd_idx), .CONFF(cf0), .flags(fl0),
    .con_valid(cv0));
  con_ff_bank #(.DATA_W(32), .NUM_FLAGS(4), .IDX_W(2), .PIPE(1)) dut1 (
    .clk(clk), .clr(clr), .bus_data(bus_data), .cond_sel(cond_sel), .combine(combine),
    .wr_idx(wr_idx), .CON_in(CON_in), .rd_idx(rd_idx), .CONFF(cf1), .flags(fl1),
    .con_valid(cv1));
  con_ff_bank #(.DATA_W(32), .NUM_FLAGS(3), .IDX_W(2), .PIPE(0)) dut2 (
    .clk(clk), .clr(clr), .bus_data(bus_data), .cond_sel(cond_sel), .combine(combine),
    .wr_idx(wr_idx), .CON_in(CON_in), .rd_idx(rd_idx), .CONFF(cf2), .flags(fl2),
    .con_valid(cv2));

  typedef struct packed {
    logic [31:0] due;
    logic [3:0]  fl;
  } exp_t;

  int   nFlags [3] = '{4, 4, 3};
  int   pipeLat[3] = '{0, 1, 0};
  exp_t expQ   [3][$];
  logic [3:0] mFlags   [3];
  logic [3:0] committed[3];
  logic [3:0] flA[3];
  logic       cfA[3];
  logic       cvA[3];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   monOn = 1'b0;

  always_comb begin
    flA[0] = fl0; flA[1] = fl1; flA[2] = {1'b0, fl2};
    cfA[0] = cf0; cfA[1] = cf1; cfA[2] = cf2;
    cvA[0] = cv0; cvA[1] = cv1; cvA[2] = cv2;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic refCond(input logic [31:0] d, input logic [2:0] sel);
    int s;
    s = $signed(d);
    case (sel)
      3'd0: return s == 0;
      3'd1: return s != 0;
      3'd2: return s >= 0;
      3'd3: return s < 0;
      3'd4: return s > 0;
      3'd5: return s <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic refComb(input logic o, input logic c, input logic [1:0] m);
    case (m)
      2'd0: return c;
      2'd1: return o && c;
      2'd2: return o || c;
      default: return o != c;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then advance the reference model past that edge.
  task automatic op(input logic c, input logic con, input logic [31:0] d,
                    input logic [2:0] sel, input logic [1:0] cmb,
                    input logic [1:0] wi, input logic [1:0] ri);
    clr = c; CON_in = con; bus_data = d; cond_sel = sel; combine = cmb;
    wr_idx = wi; rd_idx = ri;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        mFlags[k] = '0;
        committed[k] = '0;
        expQ[k].delete();
      end else if (con && (int'(wi) < nFlags[k])) begin
        exp_t e;
        mFlags[k][wi] = refComb(mFlags[k][wi], refCond(d, sel), cmb);
        e.due = 32'(cyc + pipeLat[k]);
        e.fl  = mFlags[k];
        expQ[k].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      for (int k = 0; k < 3; k++) begin
        exp_t e;
        logic expCf;
        if (cvA[k]) begin
          checks++;
          if (expQ[k].size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid dut%0d act=1 exp=0", k);
          end else begin
            e = expQ[k].pop_front();
            if (e.due != 32'(cyc)) begin
              failures++;
              $display("FAIL valid_timing dut%0d act_cycle=%0d exp_cycle=%0d", k, cyc, e.due);
            end
            committed[k] = e.fl;
          end
        end else if (expQ[k].size() != 0 && expQ[k][0].due <= 32'(cyc)) begin
          checks++;
          failures++;
          e = expQ[k].pop_front();
          $display("FAIL missing_valid dut%0d act=0 exp=1", k);
          committed[k] = e.fl;
        end
        checks++;
        if (flA[k] !== committed[k]) begin
          failures++;
          $display("FAIL flags dut%0d act=%0h exp=%0h", k, flA[k], committed[k]);
        end
        expCf = (int'(rd_idx) < nFlags[k]) ? committed[k][rd_idx] : 1'b0;
        checks++;
        if (cfA[k] !== expCf) begin
          failures++;
          $display("FAIL CONFF dut%0d rd=%0d act=%0b exp=%0b", k, rd_idx, cfA[k], expCf);
        end
      end
    end
  end

  initial begin
    logic [7:0]  tbl [3];
    logic [31:0] dv  [3];
    logic [7:0]  row;
    tbl = '{8'h65, 8'h56, 8'h6A};
    dv  = '{32'h0000_0000, 32'h0000_0005, 32'h8000_0000};

    // Reset with a write strobe present: clr must win
    op(1'b1, 1'b1, 32'h0, 3'd6, 2'd0, 2'd1, 2'd1);
    monOn = 1'b1;
    chk("reset_flags0", 32'(fl0), 32'h0);
    chk("reset_valid0", 32'(cv0), 32'h0);
    chk("reset_conff0", 32'(cf0), 32'h0);
    chk("reset_flags1", 32'(fl1), 32'h0);

    // Condition table on flag 1
    for (int di = 0; di < 3; di++) begin
      row = tbl[di];
      for (int s = 0; s < 8; s++) begin
        op(1'b0, 1'b1, dv[di], 3'(s), 2'd0, 2'd1, 2'd1);
        chk($sformatf("cond_d%0d_sel%0d", di, s), 32'(fl0[1]), 32'(row[s]));
      end
    end

    // Combine modes back to back on flag 2
    op(1'b0, 1'b1, 32'h1234, 3'd6, 2'd0, 2'd2, 2'd2);
    chk("comb_write", 32'(cf0), 32'h1);
    op(1'b0, 1'b1, 32'h1234, 3'd7, 2'd1, 2'd2, 2'd2);
    chk("comb_and", 32'(cf0), 32'h0);
    op(1'b0, 1'b1, 32'h1234, 3'd6, 2'd2, 2'd2, 2'd2);
    chk("comb_or", 32'(cf0), 32'h1);
    op(1'b0, 1'b1, 32'h1234, 3'd6, 2'd3, 2'd2, 2'd2);
    chk("comb_xor", 32'(cf0), 32'h0);
    op(1'b0, 1'b0, 32'h0, 3'd0, 2'd0, 2'd0, 2'd2);

    // Pipelined latency, then a staged op cancelled by clr
    op(1'b1, 1'b0, 32'h0, 3'd0, 2'd0, 2'd0, 2'd3);
    op(1'b0, 1'b1, 32'h0, 3'd0, 2'd0, 2'd3, 2'd3);
    chk("pipe_flag_early", 32'(fl1[3]), 32'h0);
    chk("pipe_valid_early", 32'(cv1), 32'h0);
    chk("nopipe_flag", 32'(fl0[3]), 32'h1);
    chk("nf3_valid_drop", 32'(cv2), 32'h0);
    chk("nf3_flags_kept", 32'(fl2), 32'h0);
    chk("nf3_conff_oob", 32'(cf2), 32'h0);
    op(1'b0, 1'b0, 32'h0, 3'd0, 2'd0, 2'd0, 2'd3);
    chk("pipe_flag_late", 32'(fl1[3]), 32'h1);
    chk("pipe_valid_late", 32'(cv1), 32'h1);
    op(1'b1, 1'b0, 32'h0, 3'd0, 2'd0, 2'd0, 2'd3);
    op(1'b0, 1'b1, 32'h0, 3'd0, 2'd0, 2'd3, 2'd3);
    op(1'b1, 1'b0, 32'h0, 3'd0, 2'd0, 2'd0, 2'd3);
    op(1'b0, 1'b0, 32'h0, 3'd0, 2'd0, 2'd0, 2'd3);
    chk("pipe_clr_discard", 32'(fl1[3]), 32'h0);
    chk("pipe_clr_valid", 32'(cv1), 32'h0);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0: d = 32'h0;
        1: d = $urandom;
        2: d = 32'h8000_0000 | $urandom;
        default: d = 32'($urandom_range(0, 3));
      endcase
      op(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), d,
         3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
         2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 3; n++) op(1'b0, 1'b0, 32'h0, 3'd0, 2'd0, 2'd0, 2'd0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("drain_dut%0d", k), 32'(expQ[k].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
